// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch sequencer types and constants
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        EXEC   = 2'd2,
        IRQ    = 2'd3
    } fetch_state_t;

    localparam logic [63:0] INSN_BYTES         = 64'd16;
    localparam logic [63:0] WORD_BYTES         = 64'd8;
    localparam logic [63:0] RESET_PC_DEFAULT   = 64'h0;
    localparam logic [63:0] IRQ_VECTOR_DEFAULT = 64'h100;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC select: return-from-interrupt over jump over sequential
module pc_next
    import cpu_pkg::*;
(
    input  logic [63:0] pc_i,
    input  logic [63:0] epc_i,
    input  logic        jump_i,
    input  logic [63:0] jump_target_i,
    input  logic        iret_i,
    output logic [63:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i + INSN_BYTES;
        if (iret_i) begin
            pc_next_o = epc_i;
        end else if (jump_i) begin
            pc_next_o = jump_target_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-word instruction fetch sequencer with PC, redirects and interrupt entry
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [63:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        stall,
    input  logic        jump,
    input  logic [63:0] jump_target,
    input  logic        iret,
    input  logic        irq,
    output logic [63:0] opf8,
    output logic [63:0] opl8,
    output logic        exec,
    output logic [63:0] pc,
    output logic [63:0] retaddr,
    output logic [63:0] epc,
    output logic        ie
);

    fetch_state_t state_q;
    logic [63:0]  pc_q;
    logic [63:0]  epc_q;
    logic [63:0]  opf8_q;
    logic [63:0]  opl8_q;
    logic         ie_q;
    logic [63:0]  pc_d;
    logic         ie_d;

    pc_next u_pc_next (
        .pc_i          (pc_q),
        .epc_i         (epc_q),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .iret_i        (iret),
        .pc_next_o     (pc_d)
    );

    // iret re-enables interrupts early enough for a pending irq to be taken at this boundary
    assign ie_d = iret | ie_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH0;
            pc_q    <= RESET_PC;
            epc_q   <= 64'h0;
            opf8_q  <= 64'h0;
            opl8_q  <= 64'h0;
            ie_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH0: begin
                    if (mem_ready) begin
                        opf8_q  <= mem_rdata;
                        state_q <= FETCH1;
                    end
                end
                FETCH1: begin
                    if (mem_ready) begin
                        opl8_q  <= mem_rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc_q    <= pc_d;
                        ie_q    <= ie_d;
                        state_q <= (irq && ie_d) ? IRQ : FETCH0;
                    end
                end
                IRQ: begin
                    epc_q   <= pc_q;
                    pc_q    <= IRQ_VECTOR;
                    ie_q    <= 1'b0;
                    state_q <= FETCH0;
                end
                default: state_q <= FETCH0;
            endcase
        end
    end

    assign mem_rd   = (state_q == FETCH0) || (state_q == FETCH1);
    assign mem_addr = (state_q == FETCH1) ? (pc_q + WORD_BYTES) : pc_q;
    assign exec     = (state_q == EXEC);
    assign opf8     = opf8_q;
    assign opl8     = opl8_q;
    assign pc       = pc_q;
    assign retaddr  = pc_q + INSN_BYTES;
    assign epc      = epc_q;
    assign ie       = ie_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized instruction-level checks of fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        jump;
    logic [63:0] jump_target;
    logic        iret;
    logic        irq;
    logic [63:0] opf8;
    logic [63:0] opl8;
    logic        exec;
    logic [63:0] pc;
    logic [63:0] retaddr;
    logic [63:0] epc;
    logic        ie;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] m_pc;
    logic [63:0] m_epc;
    logic        m_ie;

    localparam logic [63:0] VEC = 64'h100;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .jump        (jump),
        .jump_target (jump_target),
        .iret        (iret),
        .irq         (irq),
        .opf8        (opf8),
        .opl8        (opl8),
        .exec        (exec),
        .pc          (pc),
        .retaddr     (retaddr),
        .epc         (epc),
        .ie          (ie)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_F00D, a[63:32] ^ ~a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch_phase(input logic [63:0] addr, input int wait_n);
        for (int i = 0; i <= wait_n; i++) begin
            @(negedge clk);
            chk("fetch_rd", {63'h0, mem_rd}, 64'd1);
            chk("fetch_addr", mem_addr, addr);
            chk("fetch_exec", {63'h0, exec}, 64'd0);
            mem_ready   = (i == wait_n);
            mem_rdata   = (i == wait_n) ? mem_word(addr) : {$urandom, $urandom};
            stall       = 1'($urandom);
            jump        = 1'($urandom);
            iret        = 1'($urandom);
            irq         = 1'($urandom);
            jump_target = {$urandom, $urandom};
        end
    endtask

    task automatic run_insn(input int d0, input int d1, input int nst, input logic j,
                            input logic [63:0] jt, input logic ir, input logic iq);
        logic [63:0] ipc;
        ipc = m_pc;
        fetch_phase(ipc, d0);
        fetch_phase(ipc + 64'd8, d1);
        for (int s = 0; s <= nst; s++) begin
            @(negedge clk);
            chk("exec_hi", {63'h0, exec}, 64'd1);
            chk("exec_rd", {63'h0, mem_rd}, 64'd0);
            chk("exec_pc", pc, ipc);
            chk("retaddr", retaddr, ipc + 64'd16);
            chk("opf8", opf8, mem_word(ipc));
            chk("opl8", opl8, mem_word(ipc + 64'd8));
            chk("ie", {63'h0, ie}, {63'h0, m_ie});
            chk("epc", epc, m_epc);
            mem_ready = 1'($urandom);
            mem_rdata = {$urandom, $urandom};
            if (s < nst) begin
                stall       = 1'b1;
                jump        = 1'($urandom);
                iret        = 1'($urandom);
                irq         = 1'($urandom);
                jump_target = {$urandom, $urandom};
            end else begin
                stall       = 1'b0;
                jump        = j;
                jump_target = jt;
                iret        = ir;
                irq         = iq;
            end
        end
        if (ir) begin
            m_pc = m_epc;
            m_ie = 1'b1;
        end else if (j) begin
            m_pc = jt;
        end else begin
            m_pc = m_pc + 64'd16;
        end
        if (iq && m_ie) begin
            @(negedge clk);
            chk("irq_exec", {63'h0, exec}, 64'd0);
            chk("irq_rd", {63'h0, mem_rd}, 64'd0);
            jump      = 1'b1;
            iret      = 1'b1;
            mem_ready = 1'b1;
            m_epc = m_pc;
            m_pc  = VEC;
            m_ie  = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] r;
        rst = 1'b1; mem_rdata = '0; mem_ready = 1'b0; stall = 1'b0;
        jump = 1'b0; jump_target = '0; iret = 1'b0; irq = 1'b0;
        m_pc = 64'h0; m_epc = 64'h0; m_ie = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 64'h0);
        chk("rst_exec", {63'h0, exec}, 64'd0);
        chk("rst_opf8", opf8, 64'h0);
        chk("rst_opl8", opl8, 64'h0);
        chk("rst_epc", epc, 64'h0);
        chk("rst_ie", {63'h0, ie}, 64'd0);
        rst = 1'b0;

        // basic zero-wait instruction, then waited fetch words
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("pc_after_first", m_pc, 64'd16);
        run_insn(3, 2, 0, 1'b0, 64'h0, 1'b0, 1'b0);
        // stalled jump
        run_insn(0, 0, 2, 1'b1, 64'h400, 1'b0, 1'b0);
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
        // enable interrupts via iret, reach 0x80, take irq, return
        run_insn(1, 0, 0, 1'b0, 64'h0, 1'b1, 1'b0);
        run_insn(0, 0, 0, 1'b1, 64'h80, 1'b0, 1'b0);
        run_insn(0, 1, 1, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("irq_epc_model", m_epc, 64'h90);
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b1, 1'b0);
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);

        // reset while waiting in FETCH1; the late response must be discarded
        fetch_phase(m_pc, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_pc", pc, 64'h0);
        chk("rst_mid_addr", mem_addr, 64'h0);
        chk("rst_mid_opf8", opf8, 64'h0);
        chk("rst_mid_ie", {63'h0, ie}, 64'd0);
        mem_ready = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("rst_late_opf8", opf8, 64'h0);
        chk("rst_late_opl8", opl8, 64'h0);
        rst = 1'b0;
        mem_ready = 1'b0;
        m_pc = 64'h0; m_epc = 64'h0; m_ie = 1'b0;
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);

        // wrap at the top of the address space
        run_insn(0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("wrap_pc_model", m_pc, 64'h0);
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            r = {$urandom, $urandom};
            r[3:0] = 4'h0;
            run_insn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), r,
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
        end
        run_insn(0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
